// File: rtl/div.sv
// rtl/div.sv - multi-cycle restoring divider for DIV/DIVU in the execute stage

module div #(
    parameter int DIV_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [DIV_W-1:0]     opdata1_i,
    input  logic [DIV_W-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*DIV_W-1:0]   result_o,
    output logic                 ready_o
);

    localparam int CNT_W = $clog2(DIV_W) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_W);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t              state, state_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic [DIV_W-1:0]    rem, rem_nx;
    // dvd starts as the dividend magnitude and fills with quotient bits from the LSB
    logic [DIV_W-1:0]    dvd, dvd_nx;
    logic [DIV_W-1:0]    dvs, dvs_nx;
    logic                neg_q, neg_q_nx;
    logic                neg_r, neg_r_nx;
    logic [2*DIV_W-1:0]  result_nx;
    logic                ready_nx;

    logic [DIV_W:0]      rem_sh;
    logic [DIV_W:0]      trial;
    logic [DIV_W-1:0]    q_fix;
    logic [DIV_W-1:0]    r_fix;
    logic                op1_neg;
    logic                op2_neg;

    // State and datapath registers; reset discards any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FREE;
            cnt      <= '0;
            rem      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            rem      <= rem_nx;
            dvd      <= dvd_nx;
            dvs      <= dvs_nx;
            neg_q    <= neg_q_nx;
            neg_r    <= neg_r_nx;
            result_o <= result_nx;
            ready_o  <= ready_nx;
        end
    end

    // Next-state, one restoring iteration per ON cycle, and final sign correction
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        rem_nx    = rem;
        dvd_nx    = dvd;
        dvs_nx    = dvs;
        neg_q_nx  = neg_q;
        neg_r_nx  = neg_r;
        result_nx = result_o;
        ready_nx  = ready_o;

        op1_neg = signed_div_i & opdata1_i[DIV_W-1];
        op2_neg = signed_div_i & opdata2_i[DIV_W-1];

        // Shifted partial remainder needs one extra bit: it can exceed DIV_W bits
        // when the divisor magnitude is close to 2**DIV_W
        rem_sh = {rem, dvd[DIV_W-1]};
        trial  = rem_sh - {1'b0, dvs};

        // Most-negative / -1 wraps back to itself, which is the wanted quotient
        q_fix = neg_q ? (~dvd + 1'b1) : dvd;
        r_fix = neg_r ? (~rem + 1'b1) : rem;

        unique case (state)
            FREE: begin
                result_nx = '0;
                ready_nx  = 1'b0;
                if (start_i && !annul_i) begin
                    neg_q_nx = op1_neg ^ op2_neg;
                    neg_r_nx = op1_neg;
                    cnt_nx   = '0;
                    rem_nx   = '0;
                    dvd_nx   = op1_neg ? (~opdata1_i + 1'b1) : opdata1_i;
                    dvs_nx   = op2_neg ? (~opdata2_i + 1'b1) : opdata2_i;
                    if (opdata2_i == '0) begin
                        state_nx = BYZERO;
                    end else begin
                        state_nx = ON;
                    end
                end
            end

            BYZERO: begin
                if (annul_i) begin
                    state_nx  = FREE;
                    result_nx = '0;
                    ready_nx  = 1'b0;
                end else begin
                    state_nx  = FINISH;
                    result_nx = '0;
                    ready_nx  = 1'b1;
                end
            end

            ON: begin
                if (annul_i) begin
                    state_nx  = FREE;
                    result_nx = '0;
                    ready_nx  = 1'b0;
                    cnt_nx    = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx  = FINISH;
                    result_nx = {r_fix, q_fix};
                    ready_nx  = 1'b1;
                end else begin
                    if (!trial[DIV_W]) begin
                        rem_nx = trial[DIV_W-1:0];
                        dvd_nx = {dvd[DIV_W-2:0], 1'b1};
                    end else begin
                        rem_nx = rem_sh[DIV_W-1:0];
                        dvd_nx = {dvd[DIV_W-2:0], 1'b0};
                    end
                    cnt_nx = cnt + 1'b1;
                end
            end

            FINISH: begin
                // Result is held until ex drops its request; flush is ignored here
                if (!start_i) begin
                    state_nx  = FREE;
                    result_nx = '0;
                    ready_nx  = 1'b0;
                end
            end

            default: begin
                state_nx  = FREE;
                result_nx = '0;
                ready_nx  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_div.sv
// tb/tb_div.sv - directed self-checking bench for div

module tb_div;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_checks;
    int n_fail;

    div #(.DIV_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then settle before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full transaction: start held, operands scrambled after the start edge,
    // ready must stay low until edge lat, then result held, then release.
    task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int lat);
        logic early;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        tick();
        opdata1_i    = ~a;
        opdata2_i    = 32'h0;
        signed_div_i = ~sgn;
        early = 1'b0;
        for (int e = 2; e < lat; e++) begin
            if (ready_o !== 1'b0) early = 1'b1;
            tick();
        end
        if (ready_o !== 1'b0) early = 1'b1;
        check({tag, " ready_low_before_done"}, {63'd0, early}, 64'd0);
        tick();
        check({tag, " ready_at_latency"}, {63'd0, ready_o}, 64'd1);
        check({tag, " result"}, result_o, exp);
        tick();
        tick();
        check({tag, " held_result"}, {ready_o, result_o[62:0]}, {1'b1, exp[62:0]});
        start_i = 1'b0;
        tick();
        check({tag, " release"}, {ready_o, result_o[62:0]}, 64'd0);
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        tick();
        tick();
        check("reset_ready", {63'd0, ready_o}, 64'd0);
        check("reset_result", result_o, 64'd0);
        rst = 1'b0;
        tick();

        // Basic unsigned and signed cases
        run_op("u100_7",  1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 34);
        run_op("s-7_2",   1'b1, 32'hFFFFFFF9,   32'h00000002,   64'hFFFFFFFF_FFFFFFFD, 34);
        run_op("s7_-2",   1'b1, 32'h00000007,   32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 34);
        run_op("uF9_2",   1'b0, 32'hFFFFFFF9,   32'h00000002,   64'h00000001_7FFFFFFC, 34);

        // Divide by zero, both modes
        run_op("u_div0",  1'b0, 32'h12345678,   32'd0,          64'd0, 2);
        run_op("s_div0",  1'b1, 32'h87654321,   32'd0,          64'd0, 2);

        // Boundaries
        run_op("s_min_-1", 1'b1, 32'h80000000,  32'hFFFFFFFF,   64'h00000000_80000000, 34);
        run_op("u_max_1",  1'b0, 32'hFFFFFFFF,  32'd1,          64'h00000000_FFFFFFFF, 34);
        run_op("u_zero_dvd", 1'b0, 32'd0,       32'd5,          64'd0, 34);
        run_op("u_small",  1'b0, 32'd5,         32'd9,          64'h00000005_00000000, 34);
        run_op("u_bigdvs", 1'b0, 32'hFFFFFFFF,  32'h80000000,   64'h7FFFFFFF_00000001, 34);

        // start with annul in FREE is ignored
        start_i   = 1'b1;
        annul_i   = 1'b1;
        opdata1_i = 32'd50;
        opdata2_i = 32'd5;
        tick();
        tick();
        start_i = 1'b0;
        annul_i = 1'b0;
        tick();
        check("free_annul_ignored", {63'd0, ready_o}, 64'd0);

        // Annul at edge 10 of an ON divide
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        tick();
        for (int e = 2; e < 10; e++) tick();
        annul_i = 1'b1;
        start_i = 1'b0;
        tick();
        annul_i = 1'b0;
        begin
            logic seen;
            seen = 1'b0;
            for (int e = 0; e < 40; e++) begin
                if (ready_o !== 1'b0) seen = 1'b1;
                tick();
            end
            check("annul_no_ready", {63'd0, seen}, 64'd0);
        end
        run_op("u9_3_after_annul", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 34);

        // Reset at edge 20 of an ON divide
        signed_div_i = 1'b1;
        opdata1_i    = 32'hFFFFFF00;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        tick();
        for (int e = 2; e < 20; e++) tick();
        rst = 1'b1;
        tick();
        check("rst_mid_outputs", {ready_o, result_o[62:0]}, 64'd0);
        rst     = 1'b0;
        start_i = 1'b0;
        begin
            logic seen;
            seen = 1'b0;
            for (int e = 0; e < 40; e++) begin
                if (ready_o !== 1'b0) seen = 1'b1;
                tick();
            end
            check("rst_never_completes", {63'd0, seen}, 64'd0);
        end

        // Back-to-back with one idle cycle between
        run_op("b2b_a", 1'b1, 32'hFFFFFF9C, 32'd10,        64'h00000000_FFFFFFF6, 34);
        run_op("b2b_b", 1'b1, 32'd123,      32'hFFFFFFF6,  64'h00000003_FFFFFFF4, 34);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
